// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package mul_pkg;
    localparam int MUL_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mul_adder.sv
// Combinational W-bit adder used for the accumulate path; the carry-out is
// dropped, so the sum wraps modulo 2^W.
module mul_adder
    import mul_pkg::*;
#(
    parameter int W = 2 * MUL_N
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned N x N -> 2N multiplier, one shift-and-add step per cycle.
// Define SHIFT_ADD_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] res,
    output logic           busy
);

    localparam int CW = $clog2(N);

    state_t           r_state;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_mcand;
    logic [N-1:0]     r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_start_ready;
    logic             r_busy;
    logic             r_res_valid;

    logic [2*N-1:0]   w_sum;
    logic             w_last;

    mul_adder #(
        .W (2 * N)
    ) u_adder (
        .i_a   (r_acc),
        .i_b   (r_mcand),
        .o_sum (w_sum)
    );

`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
    // Stop once the multiplier is exhausted after this step's shift.
    assign w_last = (r_cnt == CW'(N - 1)) || (r_mplier[N-1:1] == '0);
`else
    assign w_last = (r_cnt == CW'(N - 1));
`endif

    assign start_ready = r_start_ready;
    assign busy        = r_busy;
    assign res_valid   = r_res_valid;
    assign res         = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_acc         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_cnt         <= '0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_res_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid && r_start_ready) begin
                        r_acc         <= '0;
                        r_mcand       <= {{N{1'b0}}, op_a};
                        r_mplier      <= op_b;
                        r_cnt         <= '0;
                        r_state       <= BUSY;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= w_sum;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    // Counter holds on the final step so it never wraps.
                    if (w_last) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state       <= IDLE;
                        r_res_valid   <= 1'b0;
                        r_start_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_start_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    r_res_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: stimulus pushes expected product and latency,
// a negedge monitor pops on each result handshake.
module tb_shift_add_mul;

    localparam int N = 32;

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic          res_valid;
    logic          res_ready;
    logic [63:0]   res;
    logic          busy;

    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   n_issued = 0;
    int   n_res = 0;
    exp_t q[$];

    shift_add_mul #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        chk_cnt++;
        $display("FAIL %s: bounded wait expired at cycle %0d", name, cyc);
    endtask

    // Edges from acceptance until res_valid is seen at an edge.
    function automatic int exp_lat(input logic [N-1:0] b);
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
        int bl;
        bl = 0;
        for (int i = 0; i < N; i++) if (b[i]) bl = i + 1;
        return ((bl < 1) ? 1 : bl) + 1;
`else
        return N + 1;
`endif
    endfunction

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!start_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!start_ready) begin
            fail_now("start_ready_wait");
        end else begin
            start_valid = 1'b1;
            op_a = a;
            op_b = b;
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            op_a = $urandom;
            op_b = $urandom;
            q.push_back('{prod: 64'(a) * 64'(b), acc_cyc: cyc, lat: exp_lat(b)});
            n_issued++;
            check("busy_after_accept", 64'(busy), 64'd1);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) fail_now("drain");
    endtask

    initial begin : monitor
        logic        pv;
        logic [63:0] pr;
        exp_t        e;
        pv = 1'b0;
        pr = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pv = 1'b0;
                continue;
            end
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL spurious_result: res=0x%0h with nothing outstanding", res);
                end else begin
                    if (!pv) check("latency", 64'(cyc - q[0].acc_cyc + 1), 64'(q[0].lat));
                    else     check("res_stable", res, pr);
                    if (res_ready) begin
                        e = q.pop_front();
                        check("product", res, e.prod);
                        n_res++;
                    end
                end
            end
            pv = res_valid;
            pr = res;
        end
    end

    initial begin : stim
        int w;
        int sel;
        logic [N-1:0] a;
        logic [N-1:0] b;

        rst_n = 1'b0;
        start_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res", res, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner operands.
        do_op(32'd3, 32'd5);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(32'h0000_1234, 32'd0);
        drain();

        // Consumer stalls for 10 cycles while the result is held.
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        do_op(32'd7, 32'd9);
        w = 0;
        while (!res_valid && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!res_valid) fail_now("hold_res_valid_wait");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_res", res, 64'd63);
            check("hold_start_ready", 64'(start_ready), 64'd0);
            check("hold_res_valid", 64'(res_valid), 64'd1);
            start_valid = i[0];
            op_a = $urandom;
            op_b = $urandom;
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle", 64'(start_ready), 64'd1);
        check("release_res_valid", 64'(res_valid), 64'd0);

        // Reset in the middle of an operation.
        do_op(32'h0000_00AB, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        n_issued--;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_res_valid", 64'(res_valid), 64'd0);
        check("abort_res", res, 64'd0);
        check("abort_start_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd2, 32'd2);
        drain();

        // Random back-to-back traffic.
        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 5);
            a = $urandom;
            b = $urandom;
            case (sel)
                0: b = '0;
                1: begin a = '1; b = '1; end
                2: b = N'($urandom_range(0, 255));
                default: ;
            endcase
            do_op(a, b);
        end
        drain();
        repeat (5) @(negedge clk);
        check("no_lost_results", 64'(q.size()), 64'd0);
        check("result_count", 64'(n_res), 64'(n_issued));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 SHALL have parameter: N, 32, operand width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start_valid  input  1  operand pair offered.
REQ-005 SHALL have port: start_ready  output  1  block can accept operands.
REQ-006 SHALL have port: op_a  input  N  multiplicand, unsigned.
REQ-007 SHALL have port: op_b  input  N  multiplier, unsigned.
REQ-008 SHALL have port: res_valid  output  1  product available.
REQ-009 SHALL have port: res_ready  input  1  consumer takes product.
REQ-010 SHALL have port: res  output  2N  unsigned product op_a*op_b.
REQ-011 SHALL have port: busy  output  1  high in BUSY state.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE; start_ready=1 only in IDLE; busy=1 only in BUSY; res_valid=1 only in DONE.
REQ-013 SHALL accept on the rising edge where start_valid&&start_ready: acc<=0, mcand<=zero-extended op_a (2N bits), mplier<=op_b, cnt<=0, state<=BUSY.
REQ-014 SHALL, on each BUSY edge: if mplier[0], acc<=acc+mcand (2N-bit, carry-out discarded); mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
REQ-015 SHALL leave BUSY for DONE on the edge performing step cnt==N-1, i.e. after exactly N BUSY cycles; res_valid asserts N+1 edges after acceptance edge.
REQ-016 SHALL drive res from acc continuously; res stable while res_valid=1.
REQ-017 SHALL hold DONE and res until res_valid&&res_ready; then state<=IDLE; no new accept on that same edge (one-cycle bubble).
REQ-018 SHALL ignore start_valid, op_a, op_b outside IDLE; operands sampled only at acceptance.
REQ-019 SHALL ignore res_ready outside DONE.
REQ-020 SHALL produce correct full 2N-bit product for all operands incl. 0 and 2^N-1.
REQ-021 SHALL size cnt as $clog2(N) bits; cnt never wraps during an operation.

Reset
REQ-022 SHALL, on rst_n low, asynchronously force state=IDLE, acc=0, mcand=0, mplier=0, cnt=0; outputs start_ready=1, busy=0, res_valid=0, res=0.
REQ-023 SHALL abandon any in-flight operation on reset with no result produced; first accept possible on first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL recognise macro SHIFT_ADD_MUL_EARLY_EXIT_EN.
REQ-025 SHALL, with macro defined, additionally leave BUSY for DONE after the step whose post-shift mplier is 0 (minimum 1 BUSY cycle; op_b=0 -> res_valid 2 edges after accept).
REQ-026 SHALL, with macro undefined, always take exactly N BUSY cycles; results identical in both builds.

Structure
REQ-027 SHALL place state enum (IDLE/BUSY/DONE) and default width constant MUL_N=32 in shared package mul_pkg.
REQ-028 SHALL instantiate one combinational sub-module mul_adder (2N-bit a+b, no carry-in/out) for the accumulate path; no other adders.

Verification
REQ-029 SHALL cover: op_a=3, op_b=5, res_ready=1 -> res=15, res_valid exactly 33 edges after accept (macro off), 4 edges (macro on).
REQ-030 SHALL cover: op_a=op_b=0xFFFFFFFF -> res=0xFFFFFFFE00000001, same latency both builds.
REQ-031 SHALL cover: op_b=0 (op_a=0x1234) -> res=0; latency 33 edges off, 2 edges on.
REQ-032 SHALL cover: res_ready held low 10 cycles after res_valid, op_a=7, op_b=9 -> res=63 held stable, start_ready=0, start_valid pulses ignored; release -> IDLE next edge.
REQ-033 SHALL cover: rst_n pulsed low at BUSY cycle 10 -> busy=0, res_valid=0, res=0 immediately; next op 2*2 -> res=4.
REQ-034 SHALL cover: 1000 random back-to-back operand pairs -> each res equals reference product; no lost or duplicated results.
